// File: rtl/chacha_stream_cipher_if.sv
// Plaintext-in / ciphertext-out streaming bus for chacha_stream_cipher.
// master: plaintext source plus ciphertext sink side. slave: the cipher.
interface chacha_stream_cipher_if #(
    parameter int unsigned WORD_W = 8
);
    logic [WORD_W-1:0] pt_data;
    logic              pt_valid;
    logic              pt_ready;
    logic [WORD_W-1:0] ct_data;
    logic              ct_valid;
    logic              ct_ready;

    modport master (
        output pt_data, pt_valid, ct_ready,
        input  pt_ready, ct_data, ct_valid
    );

    modport slave (
        input  pt_data, pt_valid, ct_ready,
        output pt_ready, ct_data, ct_valid
    );
endinterface

// File: rtl/chacha_stream_cipher.sv
// Small-scale ChaCha stream encrypter: builds 16-word keystream blocks from key, nonce and
// block counter (one round per cycle), XORs plaintext words with them and advances the counter.
// Optional build macro CHACHA_KS_TAP_EN adds the ks_tap output.
module chacha_stream_cipher #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned DROUNDS = 2,
    parameter int unsigned ROT_A   = 4,
    parameter int unsigned ROT_B   = 3,
    parameter int unsigned ROT_C   = 2,
    parameter int unsigned ROT_D   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*WORD_W-1:0]   key,
    input  logic [3*WORD_W-1:0]   nonce,
    input  logic [WORD_W-1:0]     init_value,
    input  logic                  lock,
    chacha_stream_cipher_if.slave stream,
    output logic                  busy,
    output logic                  ctr_wrap
`ifdef CHACHA_KS_TAP_EN
    ,
    output logic [WORD_W-1:0]     ks_tap
`endif
);

    localparam int unsigned NROUNDS = 2 * DROUNDS;
    localparam logic [4:0]  LastRnd = 5'(NROUNDS - 1);
    localparam logic [31:0] Sigma0  = 32'h61707865;
    localparam logic [31:0] Sigma1  = 32'h3320646e;
    localparam logic [31:0] Sigma2  = 32'h79622d32;
    localparam logic [31:0] Sigma3  = 32'h6b206574;

    typedef logic [15:0][WORD_W-1:0] block_t;
    typedef logic [3:0][WORD_W-1:0]  quad_t;
    typedef enum logic [1:0] {StIdle, StGen, StAdd, StStream} state_e;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    // Returns {a, b, c, d} after one quarter round.
    function automatic quad_t quarter(input logic [WORD_W-1:0] a_in, input logic [WORD_W-1:0] b_in,
                                      input logic [WORD_W-1:0] c_in, input logic [WORD_W-1:0] d_in);
        logic [WORD_W-1:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl(d ^ a, ROT_A);
        c = c + d; b = rotl(b ^ c, ROT_B);
        a = a + b; d = rotl(d ^ a, ROT_C);
        c = c + d; b = rotl(b ^ c, ROT_D);
        return {a, b, c, d};
    endfunction

    function automatic block_t init_block(input logic [8*WORD_W-1:0] k,
                                          input logic [3*WORD_W-1:0] n,
                                          input logic [WORD_W-1:0]   c);
        block_t s;
        s[0] = Sigma0[WORD_W-1:0];
        s[1] = Sigma1[WORD_W-1:0];
        s[2] = Sigma2[WORD_W-1:0];
        s[3] = Sigma3[WORD_W-1:0];
        for (int i = 0; i < 8; i++) s[4+i] = k[i*WORD_W +: WORD_W];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[i*WORD_W +: WORD_W];
        return s;
    endfunction

    state_e              state_q, state_d;
    logic [8*WORD_W-1:0] key_q;
    logic [3*WORD_W-1:0] nonce_q;
    logic [WORD_W-1:0]   ctr_q;
    logic [WORD_W-1:0]   ctr_inc;
    block_t              work_q, ks_q;
    block_t              round_out, ks_add, cur_init, next_init;
    logic [4:0]          rnd_q;
    logic [3:0]          idx_q;
    logic [WORD_W-1:0]   ct_data_q;
    logic                ct_valid_q;
    logic                wrap_q;
    logic                pt_hs;

    // Ready follows the sink; lock wins over a same-cycle handshake, so that word is not taken.
    assign stream.pt_ready = (state_q == StStream) && (!ct_valid_q || stream.ct_ready);
    assign pt_hs           = stream.pt_valid && stream.pt_ready && !lock;
    assign stream.ct_data  = ct_data_q;
    assign stream.ct_valid = ct_valid_q;
    assign busy            = (state_q == StGen) || (state_q == StAdd);
    assign ctr_wrap        = wrap_q;
    assign ctr_inc         = ctr_q + 1'b1;

    // One round per cycle: columns on even rounds, diagonals on odd rounds.
    always_comb begin
        quad_t      q;
        logic [3:0] ia, ib, ic, id;
        round_out = work_q;
        for (int i = 0; i < 4; i++) begin
            ia = 4'(i);
            ib = 4'(4 + i);
            ic = 4'(8 + i);
            id = 4'(12 + i);
            if (rnd_q[0]) begin
                ib = 4'(4 + ((i + 1) % 4));
                ic = 4'(8 + ((i + 2) % 4));
                id = 4'(12 + ((i + 3) % 4));
            end
            q = quarter(work_q[ia], work_q[ib], work_q[ic], work_q[id]);
            round_out[ia] = q[3];
            round_out[ib] = q[2];
            round_out[ic] = q[1];
            round_out[id] = q[0];
        end
    end

    // Feed-forward of the current block and the initial state of the following block.
    always_comb begin
        cur_init  = init_block(key_q, nonce_q, ctr_q);
        next_init = init_block(key_q, nonce_q, ctr_inc);
        for (int i = 0; i < 16; i++) ks_add[i] = work_q[i] + cur_init[i];
    end

    // Next-state logic; lock restarts block generation from any state.
    always_comb begin
        state_d = state_q;
        if (lock) begin
            state_d = (NROUNDS == 0) ? StAdd : StGen;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StIdle;
                StGen:    if (rnd_q == LastRnd) state_d = StAdd;
                StAdd:    state_d = StStream;
                StStream: if (pt_hs && idx_q == 4'hf) state_d = (NROUNDS == 0) ? StAdd : StGen;
                default:  state_d = StIdle;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Configuration, working state, keystream and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q      <= '0;
            nonce_q    <= '0;
            ctr_q      <= '0;
            work_q     <= '0;
            ks_q       <= '0;
            rnd_q      <= '0;
            idx_q      <= '0;
            ct_data_q  <= '0;
            ct_valid_q <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef CHACHA_KS_TAP_EN
            ks_tap     <= '0;
`endif
        end else if (lock) begin
            key_q      <= key;
            nonce_q    <= nonce;
            ctr_q      <= init_value;
            work_q     <= init_block(key, nonce, init_value);
            rnd_q      <= '0;
            idx_q      <= '0;
            ct_valid_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            if (state_q == StGen) begin
                work_q <= round_out;
                rnd_q  <= rnd_q + 5'd1;
            end
            if (state_q == StAdd) begin
                ks_q  <= ks_add;
                idx_q <= '0;
            end
            if (pt_hs) begin
                ct_data_q  <= stream.pt_data ^ ks_q[idx_q];
                ct_valid_q <= 1'b1;
                idx_q      <= idx_q + 4'd1;
`ifdef CHACHA_KS_TAP_EN
                ks_tap     <= ks_q[idx_q];
`endif
                if (idx_q == 4'hf) begin
                    ctr_q  <= ctr_inc;
                    work_q <= next_init;
                    rnd_q  <= '0;
                    if (&ctr_q) wrap_q <= 1'b1;
                end
            end else if (ct_valid_q && stream.ct_ready) begin
                ct_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/chacha_stream_cipher.md
Name: chacha_stream_cipher

Overview:
Parametrised small-scale ChaCha stream encrypter. It generalises the 8-bit-key, single-bit-stream encrypter core to a configurable word width and round count, and adds a valid/ready streaming datapath. It generates 16-word keystream blocks from key, nonce and counter, XORs plaintext words with the keystream and auto-increments the block counter. It sits between the plaintext source and the ciphertext sink in the encrypter top level.

Parameters:
WORD_W, 8, state word width in bits (4..32)
DROUNDS, 2, double-rounds per block (0..10); 0 gives feed-forward only, used for test
ROT_A, 4, first quarter-round rotate amount (1..WORD_W-1)
ROT_B, 3, second quarter-round rotate amount
ROT_C, 2, third quarter-round rotate amount
ROT_D, 1, fourth quarter-round rotate amount

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
key  in  8*WORD_W  key; word k is key[k*WORD_W +: WORD_W]
nonce  in  3*WORD_W  nonce words 0..2
init_value  in  WORD_W  initial block counter
lock  in  1  one-cycle pulse; samples key, nonce and init_value, then starts block 0
pt_data  in  WORD_W  plaintext word
pt_valid  in  1  plaintext valid
pt_ready  out  1  plaintext accepted when pt_valid && pt_ready
ct_data  out  WORD_W  ciphertext word (registered)
ct_valid  out  1  ciphertext valid
ct_ready  in  1  sink ready
busy  out  1  high in GEN or ADD
ctr_wrap  out  1  sticky; set when the counter wraps from all-ones to 0; cleared by lock

Behaviour:
- Reset (async): state IDLE; pt_ready=0, ct_valid=0, ct_data=0, busy=0, ctr_wrap=0; key, nonce, counter and keystream registers cleared.
- Initial state words: 0-3 hold the constants, i.e. the low WORD_W bits of 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Words 4-11 hold the key, word 12 the counter, words 13-15 the nonce.
- Quarter round (a,b,c,d): a+=b; d^=a; d<<<=ROT_A; c+=d; b^=c; b<<<=ROT_B; a+=b; d^=a; d<<<=ROT_C; c+=d; b^=c; b<<<=ROT_D. All addition is modulo 2^WORD_W.
- One round per cycle, with four quarter rounds in parallel. Even rounds operate on columns, odd rounds on diagonals, in standard ChaCha index order.
- FSM:
  - IDLE: wait for lock, then go to GEN.
  - GEN: run 2*DROUNDS cycles, then go to ADD. With DROUNDS=0, go straight to ADD.
  - ADD: one cycle. Keystream ks[i] = working[i] + initial[i]. idx=0. Go to STREAM.
  - STREAM: serve ks[0..15].
- Block latency from lock (or from the last word of the previous block) to pt_ready=1 is 2*DROUNDS+2 cycles.
- pt_ready = (state==STREAM) && (!ct_valid || ct_ready).
- On a pt handshake: ct_data <= pt_data ^ ks[idx], ct_valid <= 1, idx <= idx+1.
- ct_valid && ct_ready with no new handshake: ct_valid <= 0.
- ct_data is held stable while ct_valid && !ct_ready.
- After the handshake at idx=15: counter <= counter+1 (mod 2^WORD_W) and go to GEN. The pending ct word still drains normally.
- Counter at all-ones increments to 0 and sets ctr_wrap; the stream continues.
- lock in any state:
  - Aborts the current block and discards any unconsumed keystream.
  - Clears ct_valid the same cycle.
  - Reloads the configuration, clears ctr_wrap, and goes to GEN.
  - lock has priority over a simultaneous pt handshake; that pt word is not accepted.
- pt_valid is ignored outside STREAM.
- Reset mid-operation returns to IDLE immediately.

Optional Feature:
CHACHA_KS_TAP_EN:
- Defined: adds output port ks_tap [WORD_W-1:0], registered alongside ct_data and holding the keystream word used for the current ct_data. Reset value 0.
- Undefined: no port and no extra registers.

Test Plan:
- Feed-forward check:
  - Stimulus: DROUNDS=0, WORD_W=8, key word0=0xDB, other key words=0, nonce=0, init_value=0x01; lock; stream 16 words of 0x00 with ct_ready=1.
  - Response: pt_ready rises 2 cycles after lock. Output sequence is 0xCA, 0xDC, 0x64, 0xE8, 0xB6, then 0x00 x7, then 0x02, then 0x00 x3.
- Latency and round trip:
  - Stimulus: DROUNDS=2; lock, then encrypt 0x5A,0xA5,0x3C; relock with the same config and feed the ciphertext back in.
  - Response: first pt_ready 6 cycles after lock; the second pass outputs 0x5A,0xA5,0x3C.
- Backpressure:
  - Stimulus: hold ct_ready=0 for 5 cycles with pt_valid=1.
  - Response: pt_ready=0 after the first word; ct_data is stable; no word is lost or duplicated when ct_ready returns to 1.
- Block rollover and counter wrap:
  - Stimulus: init_value=0xFF; stream 20 words.
  - Response: busy is high for 2*DROUNDS+1 cycles after word 16; ctr_wrap=1; word 17 matches a fresh lock with init_value=0x00, word 0.
- Lock and reset mid-stream:
  - Stimulus: lock at idx=7 with ct_valid=1, then reset during GEN.
  - Response: ct_valid=0 the next cycle; the stream restarts at ks[0] of the new config; after reset all outputs are 0 and the FSM is in IDLE.
